// File: rtl/cr_kme_beat_packer.sv
// Packs BEATS consecutive IN_W-bit beats into one FIFO entry for the KME staging FIFO.
// Entries closed early by end-of-packet are zero-padded; writes are held off while the FIFO stalls.

module cr_kme_beat_slot #(
    parameter int IN_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            clear,
    input  logic [IN_W-1:0] din,
    output logic [IN_W-1:0] q
);
    always_ff @(posedge clk) begin
        if (rst || clear) q <= '0;
        else if (load)    q <= din;
    end
endmodule

module cr_kme_beat_packer #(
    parameter int IN_W  = 32,
    parameter int BEATS = 3,
    parameter int CNT_W = 16,
    parameter int OUT_W = IN_W * BEATS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_valid,
    input  logic             in_eop,
    output logic             in_ready,
    output logic [OUT_W-1:0] fifo_in,
    output logic             fifo_in_valid,
    input  logic             fifo_in_stall,
    output logic             busy,
    output logic [CNT_W-1:0] entry_cnt,
    output logic [CNT_W-1:0] pad_cnt
);
    localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(BEATS - 1);

    logic [IDX_W-1:0]             idx;
    logic [BEATS-1:0][IN_W-1:0]   acc;
    logic [BEATS-1:0][IN_W-1:0]   merged;
    logic [OUT_W-1:0]             out_reg;
    logic                         out_valid;
    logic                         accept, close, drain;

    assign in_ready      = !(out_valid && fifo_in_stall);
    // Gated by rst so a pending entry is dropped rather than written during reset.
    assign fifo_in_valid = out_valid && !fifo_in_stall && !rst;
    assign fifo_in       = out_reg;
    assign busy          = (idx != '0) || out_valid;

    assign accept = in_valid && in_ready;
    assign close  = accept && ((idx == LAST) || in_eop);
    assign drain  = fifo_in_valid;

    // One holding slot per beat position; the closing beat bypasses its slot into out_reg.
    for (genvar i = 0; i < BEATS; i++) begin : g_slot
        cr_kme_beat_slot #(.IN_W(IN_W)) u_slot (
            .clk   (clk),
            .rst   (rst),
            .load  (accept && !close && (idx == IDX_W'(i))),
            .clear (close),
            .din   (in_data),
            .q     (acc[i])
        );

        always_comb begin
            merged[i] = '0;
            if (idx == IDX_W'(i))      merged[i] = in_data;
            else if (IDX_W'(i) < idx)  merged[i] = acc[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx       <= '0;
            out_valid <= 1'b0;
            out_reg   <= '0;
            entry_cnt <= '0;
            pad_cnt   <= '0;
        end else begin
            if (close) begin
                idx       <= '0;
                out_reg   <= merged;
                out_valid <= 1'b1;
                if (in_eop && (idx != LAST)) pad_cnt <= pad_cnt + 1'b1;
            end else begin
                if (accept) idx <= idx + 1'b1;
                if (drain)  out_valid <= 1'b0;
            end
            if (drain) entry_cnt <= entry_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_cr_kme_beat_packer.sv
// Directed bench for cr_kme_beat_packer with a queue scoreboard of expected FIFO entries.

module tb_cr_kme_beat_packer;
    localparam int IN_W  = 32;
    localparam int BEATS = 3;
    localparam int CNT_W = 16;
    localparam int OUT_W = 96;

    logic             clk = 1'b0;
    logic             rst;
    logic [IN_W-1:0]  in_data;
    logic             in_valid;
    logic             in_eop;
    logic             in_ready;
    logic [OUT_W-1:0] fifo_in;
    logic             fifo_in_valid;
    logic             fifo_in_stall;
    logic             busy;
    logic [CNT_W-1:0] entry_cnt;
    logic [CNT_W-1:0] pad_cnt;

    cr_kme_beat_packer #(.IN_W(IN_W), .BEATS(BEATS), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_eop        (in_eop),
        .in_ready      (in_ready),
        .fifo_in       (fifo_in),
        .fifo_in_valid (fifo_in_valid),
        .fifo_in_stall (fifo_in_stall),
        .busy          (busy),
        .entry_cnt     (entry_cnt),
        .pad_cnt       (pad_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int refusals = 0;
    int m_idx = 0;
    logic [OUT_W-1:0] m_acc = '0;
    logic [OUT_W-1:0] sbq[$];
    int wr_cyc[$];

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [OUT_W-1:0] obs, input logic [OUT_W-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every FIFO write must match the oldest expected entry.
    always begin
        @(negedge clk);
        #2;
        if (fifo_in_valid === 1'b1) begin
            wr_cyc.push_back(cyc);
            if (sbq.size() == 0) begin
                n_vec++;
                n_err++;
                $error("FAIL unexpected_write: observed %0h expected no write", fifo_in);
            end else begin
                chk("entry", fifo_in, sbq.pop_front());
            end
        end
    end

    task automatic beat(input logic [IN_W-1:0] d, input logic eop);
        int t = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_eop   = eop;
        #1;
        while (in_ready !== 1'b1 && t < 200) begin
            @(negedge clk);
            #1;
            t++;
        end
        refusals += t;
        if (t >= 200) begin
            n_vec++;
            n_err++;
            $error("FAIL ready_timeout: observed in_ready=%b expected 1 within 200 cycles", in_ready);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        m_acc[m_idx*IN_W +: IN_W] = d;
        if (m_idx == BEATS-1 || eop) begin
            sbq.push_back(m_acc);
            m_idx = 0;
            m_acc = '0;
        end else begin
            m_idx++;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b0;
            in_data  = $urandom;
            in_eop   = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_idx = 0;
        m_acc = '0;
    endtask

    initial begin
        int bad_gap;
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        in_eop = 1'b0;
        fifo_in_stall = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_fifo_in_valid", fifo_in_valid, 0);
        chk("rst_fifo_in", fifo_in, 0);
        chk("rst_busy", busy, 0);
        chk("rst_entry_cnt", entry_cnt, 0);
        chk("rst_pad_cnt", pad_cnt, 0);
        rst = 1'b0;

        // Full three-beat entry; write visible the cycle after the closing beat.
        beat(32'h11111111, 1'b0);
        beat(32'h22222222, 1'b0);
        beat(32'h33333333, 1'b0);
        chk("t1_valid", fifo_in_valid, 1);
        chk("t1_data", fifo_in, 96'h333333332222222211111111);
        idle(1);
        chk("t1_entry_cnt", entry_cnt, 1);
        chk("t1_pad_cnt", pad_cnt, 0);
        chk("t1_busy", busy, 0);

        // Single-beat packet is padded; next entry restarts at the LSBs.
        beat(32'hAAAAAAAA, 1'b1);
        chk("t2_data", fifo_in, 96'h0000000000000000AAAAAAAA);
        idle(1);
        chk("t2_pad_cnt", pad_cnt, 1);
        beat(32'h01010101, 1'b0);
        beat(32'h02020202, 1'b0);
        beat(32'h03030303, 1'b0);
        chk("t2_restart", fifo_in, 96'h030303030202020201010101);
        // eop on the last slot is a full close; eop on slot 1 pads.
        beat(32'h44444444, 1'b0);
        beat(32'h55555555, 1'b0);
        beat(32'h66666666, 1'b1);
        idle(1);
        chk("t2_full_eop_pad", pad_cnt, 1);
        beat(32'h77777777, 1'b0);
        beat(32'h88888888, 1'b1);
        chk("t2_two_beat", fifo_in, 96'h000000008888888877777777);
        idle(1);
        chk("t2_pad_cnt2", pad_cnt, 2);
        chk("t2_entry_cnt", entry_cnt, 5);

        // Stall held: entry 1 pends, beats are refused until it drains.
        fifo_in_stall = 1'b1;
        beat(32'hB0000001, 1'b0);
        beat(32'hB0000002, 1'b0);
        beat(32'hB0000003, 1'b0);
        in_valid = 1'b0;
        chk("t3_no_write", fifo_in_valid, 0);
        chk("t3_ready_low", in_ready, 0);
        chk("t3_busy", busy, 1);
        idle(3);
        chk("t3_hold_data", fifo_in, 96'hB0000003B0000002B0000001);
        chk("t3_still_no_write", fifo_in_valid, 0);
        fifo_in_stall = 1'b0;
        beat(32'hB0000004, 1'b0);
        beat(32'hB0000005, 1'b0);
        fifo_in_stall = 1'b1;
        beat(32'hB0000006, 1'b0);
        in_valid = 1'b0;
        chk("t3_ready_low2", in_ready, 0);
        idle(2);
        chk("t3_hold_data2", fifo_in, 96'hB0000006B0000005B0000004);
        fifo_in_stall = 1'b0;
        idle(1);
        chk("t3_entry_cnt", entry_cnt, 7);

        // Sustained stream: one write every BEATS cycles, no refusals.
        do_reset();
        wr_cyc.delete();
        refusals = 0;
        for (int i = 0; i < 30; i++) beat(32'hC0000000 + i, 1'b0);
        idle(2);
        chk("t4_writes", wr_cyc.size(), 10);
        bad_gap = 0;
        for (int i = 1; i < wr_cyc.size(); i++)
            if (wr_cyc[i] - wr_cyc[i-1] != BEATS) bad_gap++;
        chk("t4_gaps", bad_gap, 0);
        chk("t4_refusals", refusals, 0);
        chk("t4_entry_cnt", entry_cnt, 10);

        // Reset mid-entry discards the partial beats.
        beat(32'hDEADBEEF, 1'b0);
        beat(32'hFEEDFACE, 1'b0);
        do_reset();
        chk("t5_busy", busy, 0);
        chk("t5_no_write", fifo_in_valid, 0);
        chk("t5_entry_cnt", entry_cnt, 0);
        beat(32'h0000000A, 1'b0);
        beat(32'h0000000B, 1'b0);
        beat(32'h0000000C, 1'b0);
        chk("t5_clean", fifo_in, 96'h0000000C0000000B0000000A);
        idle(1);
        chk("t5_entry_cnt1", entry_cnt, 1);

        // Counter wrap: 65537 single-beat packets, drain and close every cycle.
        do_reset();
        for (int i = 0; i < 65537; i++) beat(i, 1'b1);
        idle(2);
        chk("t6_entry_wrap", entry_cnt, 1);
        chk("t6_pad_wrap", pad_cnt, 1);
        chk("sb_empty", sbq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
